npc_unit: RTL and testbench
===========================

# npc_unit

Next-PC generator feeding the `PC` register's `NPC` input in the 5-stage MIPS core. It selects among sequential fetch (`PC+4`), the resolved EX branch, ID-stage direct jumps (`j`/`jal`) and register jumps (`jr`), and emits an IF flush. A redirect that arrives while the PC is stalled (`PC_Write_Final=0`) is held until the PC register accepts it. An optional 4-entry return-address stack lets `jr $ra` redirect before its register operand is ready.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset; the reset value of `NPC` is `RESET_PC+4`.
- `RAS_DEPTH`, 4, number of return-address stack entries; must be a power of 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PC`  in  32  current fetch PC, taken from the `PC` register output.
- `PC_Write_Final`  in  1  PC register loads `NPC` at this edge.
- `br_valid`  in  1  EX branch resolved this cycle.
- `br_taken`  in  1  branch taken; qualified by `br_valid`.
- `br_target`  in  32  branch target.
- `jmp_valid`  in  1  ID holds `j`/`jal`.
- `jmp_link`  in  1  the ID instruction is `jal`; push `link_addr`.
- `jmp_target`  in  32  `{PC_id[31:28], imm26, 2'b00}`.
- `link_addr`  in  32  return address of the `jal`.
- `jr_valid`  in  1  ID holds `jr`.
- `jr_ra`  in  1  `jr` source register is $31.
- `jr_tgt_rdy`  in  1  forwarded `rs` value is valid.
- `jr_target`  in  32  forwarded `rs` value.
- `NPC`  out  32  next PC, combinational.
- `flush`  out  1  squash the IF/ID instruction; combinational.
- `jr_wait`  out  1  `jr` cannot redirect this cycle; the hazard unit must stall.

## Operation
- Redirect candidates, highest priority first:
  - br: `br_valid & br_taken`.
  - jr: `jr_valid & (jr_tgt_rdy | ras_pred)`.
  - jmp: `jmp_valid`.
  - A lower-priority candidate in the same cycle is dropped, including its RAS push or pop.
- Pending register `pend_v` / `pend_pc`:
  - If a redirect occurs while `PC_Write_Final=0` and `pend_v=0`, the target is latched and `pend_v` is set.
  - While `pend_v=1`, new ID/EX redirects are ignored, because they belong to squashed younger instructions.
- `NPC` selection:
  - `pend_v` → `pend_pc`.
  - Otherwise the live redirect target.
  - Otherwise `PC+4`, with 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
- `flush = PC_Write_Final & (pend_v | live redirect)`. `pend_v` clears on that edge.
- `jr_wait = jr_valid & ~jr_tgt_rdy & ~ras_pred & ~pend_v & ~(br_valid & br_taken)`.
- RAS updates occur only on an accepted redirect, i.e. the one whose target reaches `NPC` with `PC_Write_Final=1`, or the one latched into pending.
  - push: the jmp redirect with `jmp_link`. At full depth, the oldest entry is overwritten and count saturates at `RAS_DEPTH`.
  - pop: a jr redirect with `jr_ra` and count>0. Pop on empty has no effect.
- Reset values: `pend_v=0`, `pend_pc=0`, RAS count=0, RAS pointer=0. Outputs depend on `PC`: with `PC=RESET_PC`, `NPC=RESET_PC+4`, `flush=0`, `jr_wait=0`.
- Reset asserted mid-stall discards the pending redirect.

## Timing
- `NPC`, `flush` and `jr_wait` are combinational from the inputs and the registered state; the path is a single mux level after the adder.
- Redirect latency: the target appears in `PC` one edge after the cycle where `PC_Write_Final=1`.
- A redirect presented under a stall of N cycles loads `PC` at the first edge with `PC_Write_Final=1`, N cycles later.
- Pending state and RAS update only on rising `clk`.

## Configuration
- `NPC_RAS_EN` defined:
  - RAS instantiated.
  - `ras_pred = jr_ra & ~jr_tgt_rdy & count>0`.
  - When `ras_pred`, the jr target is the RAS top.
  - When `jr_tgt_rdy=1`, `jr_target` always wins and a pop still occurs if `jr_ra`.
- `NPC_RAS_EN` undefined:
  - No RAS storage.
  - `ras_pred=0`; `jr` waits for `jr_tgt_rdy`.
  - `jmp_link` ignored.

## Structure
- Shared package `npc_pkg`: `RESET_PC`, `RAS_DEPTH`, redirect-source enum `{SRC_SEQ, SRC_BR, SRC_JR, SRC_JMP, SRC_PEND}`.
- One sub-module `npc_ras`:
  - Circular stack with push, pop, top and count ports.
  - Same `clk` and `rst`.
  - Instantiated only under `NPC_RAS_EN`.

## Test plan
- After reset, `PC=0`, no redirects → `NPC=4`, `flush=0`. `PC=32'hFFFF_FFFC` → `NPC=0`.
- `PC=0x100`, `br_valid=br_taken=1`, `br_target=0x200`, `jmp_valid=1`, `jmp_target=0x300` in the same cycle → `NPC=0x200`, `flush=1`.
- `jmp_valid=1`, target 0x400, `PC_Write_Final=0` for 3 cycles, and in cycle 2 `br_taken` with target 0x500 → `pend_pc=0x400` held. On the first `PC_Write_Final=1` cycle: `NPC=0x400`, `flush=1`, `pend_v` clears.
- `NPC_RAS_EN`: `jal` with `link_addr=0x108`, then `jr_ra=1`, `jr_tgt_rdy=0` → `NPC=0x108`, `jr_wait=0`, count returns to 0.
- `NPC_RAS_EN`: 5 `jal` with link 0x10, 0x20, 0x30, 0x40, 0x50, then 5 `jr $ra` with `jr_tgt_rdy=0` → 0x50, 0x40, 0x30, 0x20, then `jr_wait=1` on the fifth.
- Without the macro: `jr_valid=1`, `jr_tgt_rdy=0` → `jr_wait=1` and `NPC=PC+4`. Next cycle `jr_tgt_rdy=1`, `jr_target=0x80` → `NPC=0x80`.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared constants and redirect-source encoding for the next-PC generator.
package npc_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          RAS_DEPTH = 4;
  localparam int          RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int          RAS_CNT_W = $clog2(RAS_DEPTH) + 1;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JR,
    SRC_JMP,
    SRC_PEND
  } npc_src_e;

endpackage

// File: rtl/npc_if.sv
// Fetch-redirect bundle between the pipeline (master) and the next-PC unit (slave).
interface npc_if;

  logic [31:0] PC;
  logic        PC_Write_Final;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic        jmp_link;
  logic [31:0] jmp_target;
  logic [31:0] link_addr;
  logic        jr_valid;
  logic        jr_ra;
  logic        jr_tgt_rdy;
  logic [31:0] jr_target;
  logic [31:0] NPC;
  logic        flush;
  logic        jr_wait;

  modport master (
    output PC, PC_Write_Final, br_valid, br_taken, br_target,
           jmp_valid, jmp_link, jmp_target, link_addr,
           jr_valid, jr_ra, jr_tgt_rdy, jr_target,
    input  NPC, flush, jr_wait
  );

  modport slave (
    input  PC, PC_Write_Final, br_valid, br_taken, br_target,
           jmp_valid, jmp_link, jmp_target, link_addr,
           jr_valid, jr_ra, jr_tgt_rdy, jr_target,
    output NPC, flush, jr_wait
  );

endinterface

// File: rtl/npc_ras.sv
// Circular return-address stack; a push at full depth overwrites the oldest entry.
module npc_ras
  import npc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [31:0]          i_push_addr,
  input  logic                 i_pop,
  output logic [31:0]          o_top,
  output logic [RAS_CNT_W-1:0] o_count
);

  logic [31:0]          r_stack [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_ptr;
  logic [RAS_CNT_W-1:0] r_count;
  logic [RAS_PTR_W-1:0] w_top_idx;
  logic                 w_full;
  logic                 w_empty;

  // r_ptr names the next free slot, so the top lives one below it.
  assign w_top_idx = r_ptr - RAS_PTR_W'(1);
  assign w_full    = (r_count == RAS_CNT_W'(RAS_DEPTH));
  assign w_empty   = (r_count == '0);
  assign o_top     = r_stack[w_top_idx];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + RAS_PTR_W'(1);
      if (!w_full)
        r_count <= r_count + RAS_CNT_W'(1);
    end else if (i_pop && !w_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - RAS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push)
      r_stack[r_ptr] <= i_push_addr;
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC select with stall-held redirects; `define NPC_RAS_EN adds a return-address
// stack so `jr $ra` can redirect before its operand is forwarded.
module npc_unit
  import npc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  npc_if.slave bus
);

  logic                 r_pend_v;
  logic [31:0]          r_pend_pc;
  logic                 w_br_go;
  logic                 w_jr_go;
  logic                 w_live;
  logic                 w_ras_pred;
  logic [31:0]          w_ras_top;
  logic [31:0]          w_tgt;
  logic [31:0]          w_pc_plus4;
  npc_src_e             w_src;

`ifdef NPC_RAS_EN
  logic                 w_push;
  logic                 w_pop;
  logic [RAS_CNT_W-1:0] w_ras_count;

  // A live redirect is always accepted: it either reaches NPC now or is parked.
  assign w_push     = (w_src == SRC_JMP) & bus.jmp_link;
  assign w_pop      = (w_src == SRC_JR) & bus.jr_ra;
  assign w_ras_pred = bus.jr_ra & ~bus.jr_tgt_rdy & (w_ras_count != '0);

  npc_ras u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (bus.link_addr),
    .i_pop       (w_pop),
    .o_top       (w_ras_top),
    .o_count     (w_ras_count)
  );
`else
  logic w_unused_ras;

  assign w_ras_pred   = 1'b0;
  assign w_ras_top    = '0;
  assign w_unused_ras = &{1'b0, bus.jmp_link, bus.jr_ra, bus.link_addr};
`endif

  assign w_br_go    = bus.br_valid & bus.br_taken;
  assign w_jr_go    = bus.jr_valid & (bus.jr_tgt_rdy | w_ras_pred);
  assign w_pc_plus4 = bus.PC + 32'd4;

  // A parked redirect masks everything younger in ID/EX.
  always_comb begin
    w_src = SRC_SEQ;
    w_tgt = '0;
    if (r_pend_v) begin
      w_src = SRC_PEND;
    end else if (w_br_go) begin
      w_src = SRC_BR;
      w_tgt = bus.br_target;
    end else if (w_jr_go) begin
      w_src = SRC_JR;
      w_tgt = bus.jr_tgt_rdy ? bus.jr_target : w_ras_top;
    end else if (bus.jmp_valid) begin
      w_src = SRC_JMP;
      w_tgt = bus.jmp_target;
    end
  end

  assign w_live = (w_src == SRC_BR) | (w_src == SRC_JR) | (w_src == SRC_JMP);

  always_comb begin
    case (w_src)
      SRC_PEND: bus.NPC = r_pend_pc;
      SRC_SEQ:  bus.NPC = w_pc_plus4;
      default:  bus.NPC = w_tgt;
    endcase
  end

  assign bus.flush   = bus.PC_Write_Final & (r_pend_v | w_live);
  assign bus.jr_wait = bus.jr_valid & ~bus.jr_tgt_rdy & ~w_ras_pred & ~r_pend_v & ~w_br_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else if (r_pend_v) begin
      if (bus.PC_Write_Final)
        r_pend_v <= 1'b0;
    end else if (w_live && !bus.PC_Write_Final) begin
      r_pend_v  <= 1'b1;
      r_pend_pc <= w_tgt;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Directed-vector bench for npc_unit; RAS cases are built only with NPC_RAS_EN.
module tb_npc_unit;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  npc_if bus();

  npc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(
    input logic [31:0] pc,     input logic pwf,
    input logic brV,           input logic brT,    input logic [31:0] brTgt,
    input logic jV,            input logic jL,     input logic [31:0] jTgt,
    input logic [31:0] lnk,
    input logic jrV,           input logic jrRa,   input logic jrRdy,
    input logic [31:0] jrTgt);
    bus.PC             = pc;
    bus.PC_Write_Final = pwf;
    bus.br_valid       = brV;
    bus.br_taken       = brT;
    bus.br_target      = brTgt;
    bus.jmp_valid      = jV;
    bus.jmp_link       = jL;
    bus.jmp_target     = jTgt;
    bus.link_addr      = lnk;
    bus.jr_valid       = jrV;
    bus.jr_ra          = jrRa;
    bus.jr_tgt_rdy     = jrRdy;
    bus.jr_target      = jrTgt;
    #1;
  endtask

  task automatic applyIdle(input logic [31:0] pc, input logic pwf);
    applyStimulus(pc, pwf, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [31:0] npc, input logic fl, input logic jw);
    checkOutput({tag, ".NPC"},     bus.NPC,              npc);
    checkOutput({tag, ".flush"},   {31'b0, bus.flush},   {31'b0, fl});
    checkOutput({tag, ".jr_wait"}, {31'b0, bus.jr_wait}, {31'b0, jw});
  endtask

  initial begin
    rst = 1'b1;
    applyIdle(32'h0, 1'b1);
    repeat (2) nextCycle();
    rst = 1'b0;

    applyIdle(32'h0, 1'b1);
    checkAll("reset", 32'h4, 1'b0, 1'b0);
    applyIdle(32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap.NPC", bus.NPC, 32'h0);

    // Branch beats same-cycle jump
    applyStimulus(32'h100, 1, 1, 1, 32'h200, 1, 0, 32'h300, 0, 0, 0, 0, 0);
    checkAll("br_over_jmp", 32'h200, 1'b1, 1'b0);
    nextCycle();
    applyIdle(32'h200, 1'b1);
    checkAll("after_br", 32'h204, 1'b0, 1'b0);

    // Untaken branch lets the jump through
    applyStimulus(32'h200, 1, 1, 0, 32'h700, 1, 0, 32'h340, 0, 0, 0, 0, 0);
    checkAll("br_not_taken", 32'h340, 1'b1, 1'b0);
    nextCycle();

    // Jump under a 3-cycle stall; younger branch must be ignored
    applyStimulus(32'h200, 0, 0, 0, 0, 1, 0, 32'h400, 0, 0, 0, 0, 0);
    checkAll("stall1", 32'h400, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h200, 0, 1, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    checkAll("stall2", 32'h400, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h999);
    checkAll("stall3", 32'h400, 1'b0, 1'b0);
    nextCycle();
    applyIdle(32'h200, 1'b1);
    checkAll("stall_release", 32'h400, 1'b1, 1'b0);
    nextCycle();
    applyIdle(32'h400, 1'b1);
    checkAll("post_release", 32'h404, 1'b0, 1'b0);

    // jr waits for its operand, then redirects
    applyStimulus(32'h10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    checkAll("jr_wait", 32'h14, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(32'h14, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h80);
    checkAll("jr_ready", 32'h80, 1'b1, 1'b0);
    nextCycle();

    // A taken branch masks jr_wait; jr beats a jump
    applyStimulus(32'h80, 1, 1, 1, 32'h600, 0, 0, 0, 0, 1, 0, 0, 32'h0);
    checkAll("br_masks_jr", 32'h600, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(32'h600, 1, 0, 0, 0, 1, 0, 32'h300, 0, 1, 0, 1, 32'h90);
    checkAll("jr_over_jmp", 32'h90, 1'b1, 1'b0);
    nextCycle();

    // Reset during a stall drops the parked redirect
    applyStimulus(32'h300, 0, 0, 0, 0, 1, 0, 32'h600, 0, 0, 0, 0, 0);
    nextCycle();
    rst = 1'b1;
    applyIdle(32'h300, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyIdle(32'h0, 1'b1);
    checkAll("reset_mid_stall", 32'h4, 1'b0, 1'b0);

`ifdef NPC_RAS_EN
    applyStimulus(32'h100, 1, 0, 0, 0, 1, 1, 32'h1000, 32'h108, 0, 0, 0, 0);
    checkAll("jal", 32'h1000, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(32'h1000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    checkAll("ras_pop", 32'h108, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(32'h108, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    checkAll("ras_empty", 32'h10C, 1'b0, 1'b1);
    nextCycle();

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(32'h2000, 1, 0, 0, 0, 1, 1, 32'h3000, 32'(i * 16), 0, 0, 0, 0);
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
      checkAll($sformatf("ras_deep%0d", i), 32'(32'h50 - i * 16), 1'b1, 1'b0);
      nextCycle();
    end
    applyStimulus(32'h3000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    checkAll("ras_overflow_empty", 32'h3004, 1'b0, 1'b1);
    nextCycle();
`else
    applyStimulus(32'h100, 1, 0, 0, 0, 1, 1, 32'h1000, 32'h108, 0, 0, 0, 0);
    checkAll("jal_no_ras", 32'h1000, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(32'h1000, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0);
    checkAll("jr_ra_no_ras", 32'h1004, 1'b0, 1'b1);
    nextCycle();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
